hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage decode info and fetch status in,
// pipeline stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned XLEN_REG = 5
);
    logic                id_valid;
    logic [XLEN_REG-1:0] id_rs1;
    logic [XLEN_REG-1:0] id_rs2;
    logic [XLEN_REG-1:0] id_rd;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic                id_wr;
    logic                id_is_load;
    logic                ex_branch_taken;
    logic                imem_ready;

    logic                StallIF;
    logic                StallID;
    logic                EnableID;
    logic                FlushE;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [CNT_W-1:0]    stall_cnt;

    // Pipeline side: supplies decode info, consumes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_wr, id_is_load, ex_branch_taken, imem_ready,
        input  StallIF, StallID, EnableID, FlushE, fwd_a, fwd_b, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_wr, id_is_load, ex_branch_taken, imem_ready,
        output StallIF, StallID, EnableID, FlushE, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations in a shadow
// scoreboard, resolves branch flush / load-use stall / fetch wait, and
// selects operand forwarding for the instruction in EX.
module hazard_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned XLEN_REG = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {StRun, StFlush, StImemWait} state_e;

    state_e              state_q, state_d;
    logic [XLEN_REG-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q, mem_rd_q, wb_rd_q;
    logic                ex_wr_q, ex_load_q, mem_wr_q, wb_wr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic id_eff, rs1_hit, rs2_hit, load_use;
    logic stall_if, stall_id, enable_id, flush_e;

    // The instruction sitting in ID during a flush cycle is the wrong-path one.
    assign id_eff   = bus.id_valid && (state_q != StFlush);
    assign rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1 == ex_rd_q);
    assign rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2 == ex_rd_q);
    assign load_use = id_eff && ex_load_q && ex_wr_q && (ex_rd_q != '0) && (rs1_hit || rs2_hit);

    // Prioritised control decode: branch, then load-use, then fetch wait.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        enable_id = 1'b1;
        flush_e   = 1'b0;
        state_d   = StRun;
        if (bus.ex_branch_taken) begin
            flush_e = 1'b1;
            state_d = StFlush;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            enable_id = 1'b0;
            flush_e   = 1'b1;
            state_d   = state_q;
        end else if (!bus.imem_ready) begin
            stall_if  = 1'b1;
            enable_id = 1'b0;
            flush_e   = 1'b1;
            state_d   = StImemWait;
        end
    end

    // Saturating count of cycles in which the pipeline does not advance.
    always_comb begin
        cnt_d = cnt_q;
        if ((stall_if || flush_e) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, scoreboard shift (EX -> MEM -> WB) and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            ex_rd_q   <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_wr_q   <= 1'b0;
            ex_load_q <= 1'b0;
            mem_rd_q  <= '0;
            mem_wr_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_wr_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q  <= state_d;
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            wb_rd_q  <= mem_rd_q;
            wb_wr_q  <= mem_wr_q;
            cnt_q    <= cnt_d;
            if (!flush_e && id_eff) begin
                ex_rd_q   <= bus.id_rd;
                ex_rs1_q  <= bus.id_rs1;
                ex_rs2_q  <= bus.id_rs2;
                ex_wr_q   <= bus.id_wr;
                ex_load_q <= bus.id_is_load;
            end else begin
                // Bubble: all-zero fields never match a live register.
                ex_rd_q   <= '0;
                ex_rs1_q  <= '0;
                ex_rs2_q  <= '0;
                ex_wr_q   <= 1'b0;
                ex_load_q <= 1'b0;
            end
        end
    end

    // Forward select: MEM result (10) beats WB result (01); x0 never forwards.
    always_comb begin
        if (mem_wr_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
            bus.fwd_a = 2'b10;
        end else if (wb_wr_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
            bus.fwd_a = 2'b01;
        end else begin
            bus.fwd_a = 2'b00;
        end
        if (mem_wr_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
            bus.fwd_b = 2'b10;
        end else if (wb_wr_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
            bus.fwd_b = 2'b01;
        end else begin
            bus.fwd_b = 2'b00;
        end
    end

    assign bus.StallIF   = stall_if;
    assign bus.StallID   = stall_id;
    assign bus.EnableID  = enable_id;
    assign bus.FlushE    = flush_e;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a vector table of per-cycle ID/fetch inputs with
// expected controls, checked through an expected-value queue, plus hand
// sequences for counter saturation and asynchronous reset mid-stall/flush.
module tb_hazard_ctrl;
    localparam int unsigned CntW    = 4;
    localparam int unsigned XlenReg = 5;

    // Control nibble order: {StallIF, StallID, EnableID, FlushE}
    localparam logic [3:0] Run = 4'b0010;
    localparam logic [3:0] Lu  = 4'b1101;
    localparam logic [3:0] Imw = 4'b1001;
    localparam logic [3:0] Br  = 4'b0011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CntW), .XLEN_REG(XlenReg)) bus ();

    hazard_ctrl #(.CNT_W(CntW), .XLEN_REG(XlenReg)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       wr;
        logic       ld;
        logic       br;
        logic       rdy;
        logic [7:0] ctl;
        logic [3:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [7:0] ctl;
        logic [3:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic wr,
                       input logic ld, input logic br, input logic rdy, input logic [7:0] ctl,
                       input logic [3:0] cnt);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
        t.wr = wr; t.ld = ld; t.br = br; t.rdy = rdy; t.ctl = ctl; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2, input logic wr,
                         input logic ld, input logic br, input logic rdy);
        bus.id_valid        = v;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_rd           = rd;
        bus.id_uses_rs1     = u1;
        bus.id_uses_rs2     = u2;
        bus.id_wr           = wr;
        bus.id_is_load      = ld;
        bus.ex_branch_taken = br;
        bus.imem_ready      = rdy;
    endtask

    task automatic expect_push(input logic [7:0] ctl, input logic [3:0] cnt);
        exp_t e;
        e.ctl = ctl;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input string name);
        exp_t       e;
        logic [7:0] act_ctl;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e       = exp_q.pop_front();
            act_ctl = {bus.StallIF, bus.StallID, bus.EnableID, bus.FlushE, bus.fwd_a, bus.fwd_b};
            if (act_ctl !== e.ctl || bus.stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         name, act_ctl, bus.stall_cnt, e.ctl, e.cnt);
            end
        end
    endtask

    initial begin
        // load x5 -> dependent add stalls once, then gets x5 from WB
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b00, 2'b00}, 0);
        add(1, 2, 0, 5, 1, 0, 1, 1, 0, 1, {Run, 2'b00, 2'b00}, 0);
        add(1, 5, 1, 6, 1, 1, 1, 0, 0, 1, {Lu,  2'b00, 2'b00}, 0);
        add(1, 5, 1, 6, 1, 1, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 1);
        // addi x3; write x0; reader of x3/x0 two cycles later
        add(1, 0, 0, 3, 1, 0, 1, 0, 0, 1, {Run, 2'b01, 2'b00}, 1);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 1);
        add(1, 3, 0, 7, 1, 1, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 1);
        add(1, 7, 0, 0, 1, 0, 1, 1, 0, 1, {Run, 2'b01, 2'b00}, 1);
        // load to x0 followed by x0 reader: no stall; MEM forward of x7
        add(1, 0, 0, 8, 1, 1, 1, 0, 0, 1, {Run, 2'b10, 2'b00}, 1);
        add(1, 8, 8, 8, 1, 1, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 1);
        add(1, 8, 8, 9, 1, 1, 1, 0, 0, 1, {Run, 2'b10, 2'b10}, 1);
        // x8 in both MEM and WB: MEM wins
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b10, 2'b10}, 1);
        // branch, then flush cycle drops a valid load (no later load-use)
        add(1, 0, 0, 10, 0, 0, 1, 0, 1, 1, {Br,  2'b00, 2'b00}, 1);
        add(1, 0, 0, 11, 0, 0, 1, 1, 0, 1, {Run, 2'b00, 2'b00}, 2);
        add(1, 11, 0, 12, 1, 0, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 2);
        // branch + load-use + fetch miss together, then IMEM wait
        add(1, 0, 0, 13, 0, 0, 1, 1, 0, 1, {Run, 2'b00, 2'b00}, 2);
        add(1, 13, 0, 14, 1, 0, 1, 0, 1, 0, {Br,  2'b00, 2'b00}, 2);
        add(1, 13, 0, 14, 1, 0, 1, 0, 0, 0, {Imw, 2'b00, 2'b00}, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b00, 2'b00}, 4);
        // three cycles of fetch miss
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {Imw, 2'b00, 2'b00}, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {Imw, 2'b00, 2'b00}, 5);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {Imw, 2'b00, 2'b00}, 6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b00, 2'b00}, 7);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b00, 2'b00}, 7);
        // load-use through rs2 only; then WB forward on both operands
        add(1, 0, 0, 15, 0, 0, 1, 1, 0, 1, {Run, 2'b00, 2'b00}, 7);
        add(1, 15, 15, 16, 0, 1, 1, 0, 0, 1, {Lu,  2'b00, 2'b00}, 7);
        add(1, 15, 15, 16, 0, 1, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, {Run, 2'b01, 2'b01}, 8);
        // matching indices but operands not used: no stall
        add(1, 0, 0, 17, 0, 0, 1, 1, 0, 1, {Run, 2'b00, 2'b00}, 8);
        add(1, 17, 17, 18, 0, 0, 1, 0, 0, 1, {Run, 2'b00, 2'b00}, 8);

        // Reset values while held in reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        expect_push({Run, 2'b00, 2'b00}, 0);
        #2;
        check_pop("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                  vecs[i].wr, vecs[i].ld, vecs[i].br, vecs[i].rdy);
            expect_push(vecs[i].ctl, vecs[i].cnt);
            #2;
            check_pop($sformatf("vec%0d", i));
        end

        // Saturation: 20 stall cycles on a 4-bit counter
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i == 0) begin
                expect_push({Imw, 2'b00, 2'b00}, 0);
                #2;
                check_pop("sat_start");
            end
        end
        @(negedge clk);
        expect_push({Imw, 2'b00, 2'b00}, 15);
        #2;
        check_pop("sat_15");
        // Asynchronous reset mid-stall: counter clears at once
        #1;
        rst_n = 1'b0;
        #1;
        expect_push({Imw, 2'b00, 2'b00}, 0);
        check_pop("rst_mid_stall_cnt");
        bus.imem_ready = 1'b1;
        #1;
        expect_push({Run, 2'b00, 2'b00}, 0);
        check_pop("rst_mid_stall_ctl");
        @(negedge clk);
        rst_n = 1'b1;

        // MEM forward during branch, then reset during the flush cycle
        @(negedge clk);
        drive(1, 0, 0, 3, 0, 0, 1, 0, 0, 1);
        expect_push({Run, 2'b00, 2'b00}, 0);
        #2;
        check_pop("pre_br_a");
        @(negedge clk);
        drive(1, 3, 0, 4, 1, 0, 1, 0, 0, 1);
        #2;
        @(negedge clk);
        drive(1, 0, 0, 9, 0, 0, 1, 0, 1, 1);
        expect_push({Br, 2'b10, 2'b00}, 0);
        #2;
        check_pop("br_fwd_mem");
        @(negedge clk);
        drive(1, 0, 0, 5, 0, 0, 1, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        expect_push({Run, 2'b00, 2'b00}, 0);
        check_pop("rst_mid_flush");
        @(negedge clk);
        rst_n = 1'b1;
        // First cycle after release is RUN: the load is captured into EX
        expect_push({Run, 2'b00, 2'b00}, 0);
        #2;
        check_pop("post_rst_run");
        @(negedge clk);
        drive(1, 5, 0, 6, 1, 0, 1, 0, 0, 1);
        expect_push({Lu, 2'b00, 2'b00}, 0);
        #2;
        check_pop("post_rst_loaduse");
        @(negedge clk);
        expect_push({Run, 2'b00, 2'b00}, 1);
        #2;
        check_pop("post_rst_resume");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
